// File: rtl/nv_nvdla_sdp_hls_y_inp_arb.sv
// Round-robin share of one Y interpolation pipeline between ALU-LUT (0) and MUL-LUT (1) streams; 0-cycle
// combinational paths both ways; issue stalls at TAG_DEPTH in flight, and results stall on the owner's prdy.
module nv_nvdla_sdp_hls_y_inp_arb #(
  parameter int PD_IN_DW  = 256,
  parameter int PD_OUT_DW = 32,
  parameter int TAG_DEPTH = 4
) (
  input  logic                         nvdla_core_clk,
  input  logic                         nvdla_core_rstn,
  input  logic                         req0_pvld,
  input  logic [PD_IN_DW-1:0]          req0_pd,
  output logic                         req0_prdy,
  input  logic                         req1_pvld,
  input  logic [PD_IN_DW-1:0]          req1_pd,
  output logic                         req1_prdy,
  output logic                         inp_in_pvld,
  output logic [PD_IN_DW-1:0]          inp_in_pd,
  input  logic                         inp_in_prdy,
  input  logic                         inp_out_pvld,
  input  logic [PD_OUT_DW-1:0]         inp_out_pd,
  output logic                         inp_out_prdy,
  output logic                         out0_pvld,
  input  logic                         out0_prdy,
  output logic [PD_OUT_DW-1:0]         out0_pd,
  output logic                         out1_pvld,
  input  logic                         out1_prdy,
  output logic [PD_OUT_DW-1:0]         out1_pd,
  output logic [$clog2(TAG_DEPTH):0]   outstanding,
  output logic                         tag_err
);

  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = AW + 1;

  logic          r_last_gnt;
  logic          r_lock;
  logic          r_lock_id;
  logic          r_tag [TAG_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_tag_err;

  logic w_gnt;
  logic w_gnt_vld;
  logic w_can_issue;
  logic w_empty;
  logic w_head;
  logic w_req_pvld;
  logic w_fwd_rdy;
  logic w_push;
  logic w_pop;

  assign w_can_issue = (r_cnt < CW'(TAG_DEPTH));
  assign w_empty     = (r_cnt == '0);
  assign w_head      = r_tag[r_rd_ptr];

  // A stalled grant stays pinned so the pipeline sees stable pvld/pd.
  always_comb begin
    w_gnt     = 1'b0;
    w_gnt_vld = 1'b1;
    if (r_lock)
      w_gnt = r_lock_id;
    else if (req0_pvld && req1_pvld)
      w_gnt = ~r_last_gnt;
    else if (req1_pvld)
      w_gnt = 1'b1;
    else if (!req0_pvld)
      w_gnt_vld = 1'b0;
  end

  assign w_req_pvld  = w_gnt ? req1_pvld : req0_pvld;
  assign inp_in_pvld = nvdla_core_rstn & w_can_issue & w_gnt_vld & w_req_pvld;
  assign inp_in_pd   = w_gnt ? req1_pd : req0_pd;
  assign w_fwd_rdy   = nvdla_core_rstn & w_can_issue & w_gnt_vld & inp_in_prdy;
  assign req0_prdy   = w_fwd_rdy & ~w_gnt;
  assign req1_prdy   = w_fwd_rdy & w_gnt;

  assign out0_pvld    = nvdla_core_rstn & inp_out_pvld & ~w_empty & ~w_head;
  assign out1_pvld    = nvdla_core_rstn & inp_out_pvld & ~w_empty & w_head;
  assign out0_pd      = inp_out_pd;
  assign out1_pd      = inp_out_pd;
  assign inp_out_prdy = nvdla_core_rstn & ~w_empty & (w_head ? out1_prdy : out0_prdy);

  assign w_push = inp_in_pvld & inp_in_prdy;
  assign w_pop  = inp_out_pvld & inp_out_prdy;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_last_gnt <= 1'b1;
      r_lock     <= 1'b0;
      r_lock_id  <= 1'b0;
    end else if (w_push) begin
      r_last_gnt <= w_gnt;
      r_lock     <= 1'b0;
    end else if (inp_in_pvld) begin
      r_lock     <= 1'b1;
      r_lock_id  <= w_gnt;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      for (int i = 0; i < TAG_DEPTH; i++) r_tag[i] <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_tag[r_wr_ptr] <= w_gnt;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // A result with no owner is a pipeline protocol error; latch it for software.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn)
      r_tag_err <= 1'b0;
    else if (inp_out_pvld && w_empty)
      r_tag_err <= 1'b1;
  end

  assign outstanding = r_cnt;
  assign tag_err     = r_tag_err;

endmodule

// File: tb/tb_nv_nvdla_sdp_hls_y_inp_arb.sv
// Bench for the Y-path interpolation arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_nv_nvdla_sdp_hls_y_inp_arb;
  localparam int IW = 256;
  localparam int OW = 32;
  localparam int TD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          req0_pvld, req1_pvld, inp_in_prdy, inp_out_pvld, out0_prdy, out1_prdy;
  logic [IW-1:0] req0_pd, req1_pd;
  logic [OW-1:0] inp_out_pd;
  wire           req0_prdy, req1_prdy, inp_in_pvld, inp_out_prdy, out0_pvld, out1_pvld, tag_err;
  wire  [IW-1:0] inp_in_pd;
  wire  [OW-1:0] out0_pd, out1_pd;
  wire  [2:0]    outstanding;

  nv_nvdla_sdp_hls_y_inp_arb #(.PD_IN_DW(IW), .PD_OUT_DW(OW), .TAG_DEPTH(TD)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .req0_pvld(req0_pvld), .req0_pd(req0_pd), .req0_prdy(req0_prdy),
    .req1_pvld(req1_pvld), .req1_pd(req1_pd), .req1_prdy(req1_prdy),
    .inp_in_pvld(inp_in_pvld), .inp_in_pd(inp_in_pd), .inp_in_prdy(inp_in_prdy),
    .inp_out_pvld(inp_out_pvld), .inp_out_pd(inp_out_pd), .inp_out_prdy(inp_out_prdy),
    .out0_pvld(out0_pvld), .out0_prdy(out0_prdy), .out0_pd(out0_pd),
    .out1_pvld(out1_pvld), .out1_prdy(out1_prdy), .out1_pd(out1_pd),
    .outstanding(outstanding), .tag_err(tag_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: owner queue plus round-robin/lock bookkeeping.
  int   m_last, m_lock_id;
  bit   m_lock, m_err;
  int   tagq[$];
  int   e_g;
  logic e_gv, e_in_pvld, e_prdy0, e_prdy1, e_o0, e_o1, e_out_prdy;
  logic [IW-1:0] e_in_pd;

  function automatic logic [IW-1:0] rnd_pd();
    logic [IW-1:0] v;
    for (int i = 0; i < IW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    m_last = 1; m_lock = 0; m_lock_id = 0; m_err = 0;
    tagq.delete();
  endtask

  task automatic model_eval();
    bit can;
    can  = (tagq.size() < TD);
    e_gv = 1'b1;
    e_g  = 0;
    if (m_lock) e_g = m_lock_id;
    else if (req0_pvld && req1_pvld) e_g = 1 - m_last;
    else if (req0_pvld) e_g = 0;
    else if (req1_pvld) e_g = 1;
    else e_gv = 1'b0;
    e_in_pvld = e_gv && can && ((e_g == 1) ? req1_pvld : req0_pvld);
    e_in_pd   = (e_g == 1) ? req1_pd : req0_pd;
    e_prdy0   = e_gv && (e_g == 0) && can && inp_in_prdy;
    e_prdy1   = e_gv && (e_g == 1) && can && inp_in_prdy;
    if (tagq.size() == 0) begin
      e_o0 = 1'b0; e_o1 = 1'b0; e_out_prdy = 1'b0;
    end else begin
      e_o0       = inp_out_pvld && (tagq[0] == 0);
      e_o1       = inp_out_pvld && (tagq[0] == 1);
      e_out_prdy = (tagq[0] == 0) ? out0_prdy : out1_prdy;
    end
  endtask

  task automatic model_tick();
    if (inp_out_pvld && tagq.size() == 0) m_err = 1;
    if (inp_out_pvld && e_out_prdy) void'(tagq.pop_front());
    if (e_in_pvld && inp_in_prdy) begin
      tagq.push_back(e_g); m_last = e_g; m_lock = 0;
    end else if (e_in_pvld) begin
      m_lock = 1; m_lock_id = e_g;
    end
  endtask

  task automatic tick();
    model_eval();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    req0_pvld = 0; req1_pvld = 0; inp_in_prdy = 0; inp_out_pvld = 0;
    out0_prdy = 0; out1_prdy = 0; req0_pd = '0; req1_pd = '0; inp_out_pd = '0;
  endtask

  task automatic apply_reset();
    rstn = 0;
    drive_idle();
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rstn = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 0;
    req0_pvld = 1; req1_pvld = 1; inp_in_prdy = 1; inp_out_pvld = 1; out0_prdy = 1; out1_prdy = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req0_prdy, req1_prdy, inp_in_pvld, inp_out_prdy, out0_pvld, out1_pvld} !== 6'b0) begin
      errors++; $display("FAIL reset_handshakes: got %b want 000000",
        {req0_prdy, req1_prdy, inp_in_pvld, inp_out_prdy, out0_pvld, out1_pvld});
    end
    checks++;
    if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    checks++;
    if (tag_err !== 1'b0) begin errors++; $display("FAIL reset_tag_err: got %b want 0", tag_err); end
    apply_reset();
  endtask

  task automatic test_alternate();
    apply_reset();
    req0_pvld = 1; req1_pvld = 1; inp_in_prdy = 1; out0_prdy = 1; out1_prdy = 1;
    for (int i = 0; i < 10; i++) begin
      req0_pd = rnd_pd(); req1_pd = rnd_pd(); inp_out_pd = OW'($urandom);
      inp_out_pvld = (tagq.size() > 0);
      @(negedge clk);
      checks++;
      if (req0_prdy !== (i % 2 == 0) || req1_prdy !== (i % 2 == 1)) begin
        errors++; $display("FAIL alt_grant c%0d: got prdy0=%b prdy1=%b want gnt %0d", i, req0_prdy, req1_prdy, i % 2);
      end
      checks++;
      if (inp_in_pd !== ((i % 2 == 1) ? req1_pd : req0_pd)) begin
        errors++; $display("FAIL alt_pd c%0d: got %h", i, inp_in_pd[31:0]);
      end
      checks++;
      if (out0_pvld !== (i >= 1 && i % 2 == 1) || out1_pvld !== (i >= 2 && i % 2 == 0)) begin
        errors++; $display("FAIL alt_steer c%0d: got out0=%b out1=%b", i, out0_pvld, out1_pvld);
      end
      checks++;
      if (out0_pvld === 1'b1 && out0_pd !== inp_out_pd) begin
        errors++; $display("FAIL alt_out0_pd c%0d: got %h want %h", i, out0_pd, inp_out_pd);
      end
      tick();
    end
  endtask

  task automatic test_lock();
    logic [IW-1:0] p;
    apply_reset();
    req0_pvld = 1; req0_pd = rnd_pd(); inp_in_prdy = 1;
    @(negedge clk);
    checks++;
    if (req0_prdy !== 1'b1) begin errors++; $display("FAIL lock_first_issue: got %b want 1", req0_prdy); end
    tick();
    p = rnd_pd(); req0_pd = p; inp_in_prdy = 0;
    for (int k = 0; k < 3; k++) begin
      req1_pvld = (k >= 1); req1_pd = rnd_pd();
      @(negedge clk);
      checks++;
      if (inp_in_pvld !== 1'b1 || inp_in_pd !== p || req1_prdy !== 1'b0) begin
        errors++; $display("FAIL lock_stall c%0d: got pvld=%b pd_ok=%b prdy1=%b want 1 1 0",
          k, inp_in_pvld, inp_in_pd === p, req1_prdy);
      end
      tick();
    end
    inp_in_prdy = 1;
    @(negedge clk);
    checks++;
    if (req0_prdy !== 1'b1 || req1_prdy !== 1'b0 || inp_in_pd !== p) begin
      errors++; $display("FAIL lock_release: got prdy0=%b prdy1=%b want 1 0", req0_prdy, req1_prdy);
    end
    tick();
    req0_pd = rnd_pd();
    @(negedge clk);
    checks++;
    if (req1_prdy !== 1'b1 || req0_prdy !== 1'b0 || inp_in_pd !== req1_pd) begin
      errors++; $display("FAIL lock_next_gnt: got prdy0=%b prdy1=%b want 0 1", req0_prdy, req1_prdy);
    end
    tick();
    @(negedge clk);
    checks++;
    if (outstanding !== 3'd3) begin errors++; $display("FAIL lock_outstanding: got %0d want 3", outstanding); end
  endtask

  task automatic test_full();
    apply_reset();
    req0_pvld = 1; req1_pvld = 1; inp_in_prdy = 1;
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if (outstanding !== 3'd4 || inp_in_pvld !== 1'b0 || req0_prdy !== 1'b0 || req1_prdy !== 1'b0) begin
      errors++; $display("FAIL full_block: got outstanding=%0d pvld=%b want 4 0", outstanding, inp_in_pvld);
    end
    tick();
    inp_out_pvld = 1; out0_prdy = 1; out1_prdy = 1;
    @(negedge clk);
    checks++;
    if (inp_out_prdy !== 1'b1 || out0_pvld !== 1'b1 || inp_in_pvld !== 1'b0) begin
      errors++; $display("FAIL full_pop_no_bypass: got oprdy=%b out0=%b in_pvld=%b want 1 1 0",
        inp_out_prdy, out0_pvld, inp_in_pvld);
    end
    tick();
    inp_out_pvld = 0;
    @(negedge clk);
    checks++;
    if (outstanding !== 3'd3 || inp_in_pvld !== 1'b1) begin
      errors++; $display("FAIL full_resume: got outstanding=%0d pvld=%b want 3 1", outstanding, inp_in_pvld);
    end
    tick();
  endtask

  task automatic test_order();
    logic [1:0] pat [4];
    logic [2:0] exp_steer [6];
    pat = '{2'b01, 2'b10, 2'b10, 2'b01};
    exp_steer = '{3'b101, 3'b010, 3'b010, 3'b011, 3'b011, 3'b101};
    apply_reset();
    inp_in_prdy = 1;
    for (int i = 0; i < 4; i++) begin
      {req1_pvld, req0_pvld} = pat[i];
      req0_pd = rnd_pd(); req1_pd = rnd_pd();
      @(negedge clk);
      checks++;
      if ({req1_prdy, req0_prdy} !== pat[i]) begin
        errors++; $display("FAIL order_issue c%0d: got %b want %b", i, {req1_prdy, req0_prdy}, pat[i]);
      end
      tick();
    end
    req0_pvld = 0; req1_pvld = 0; inp_in_prdy = 0;
    inp_out_pvld = 1; out0_prdy = 1;
    for (int c = 0; c < 6; c++) begin
      out1_prdy = (c >= 3);
      inp_out_pd = OW'($urandom);
      @(negedge clk);
      checks++;
      if ({out0_pvld, out1_pvld, inp_out_prdy} !== exp_steer[c]) begin
        errors++; $display("FAIL order_steer c%0d: got %b want %b", c, {out0_pvld, out1_pvld, inp_out_prdy}, exp_steer[c]);
      end
      checks++;
      if (out1_pvld === 1'b1 && out1_pd !== inp_out_pd) begin
        errors++; $display("FAIL order_out1_pd c%0d: got %h want %h", c, out1_pd, inp_out_pd);
      end
      tick();
    end
    inp_out_pvld = 0;
    @(negedge clk);
    checks++;
    if (outstanding !== 3'd0) begin errors++; $display("FAIL order_drained: got %0d want 0", outstanding); end
  endtask

  task automatic test_tag_err();
    apply_reset();
    inp_out_pvld = 1; out0_prdy = 1; out1_prdy = 1;
    @(negedge clk);
    checks++;
    if (inp_out_prdy !== 1'b0 || out0_pvld !== 1'b0 || out1_pvld !== 1'b0) begin
      errors++; $display("FAIL tagerr_block: got prdy=%b out0=%b out1=%b want 0 0 0", inp_out_prdy, out0_pvld, out1_pvld);
    end
    tick();
    inp_out_pvld = 0;
    @(negedge clk);
    checks++;
    if (tag_err !== 1'b1) begin errors++; $display("FAIL tagerr_set: got %b want 1", tag_err); end
    repeat (3) tick();
    checks++;
    if (tag_err !== 1'b1) begin errors++; $display("FAIL tagerr_sticky: got %b want 1", tag_err); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req0_pvld = 1; req1_pvld = 1; inp_in_prdy = 1;
    repeat (2) tick();
    req0_pvld = 0; inp_in_prdy = 0;
    tick();
    @(negedge clk);
    checks++;
    if (outstanding !== 3'd2) begin errors++; $display("FAIL midrst_setup: got %0d want 2", outstanding); end
    tick();
    req0_pvld = 1; req1_pvld = 1; inp_in_prdy = 1; out0_prdy = 1; out1_prdy = 1;
    #2 rstn = 0;
    #1;
    checks++;
    if (outstanding !== 3'd0 || {req0_prdy, req1_prdy, inp_in_pvld, inp_out_prdy, out0_pvld, out1_pvld} !== 6'b0) begin
      errors++; $display("FAIL midrst_async: got outstanding=%0d hs=%b want 0 000000", outstanding,
        {req0_prdy, req1_prdy, inp_in_pvld, inp_out_prdy, out0_pvld, out1_pvld});
    end
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rstn = 1;
    #1;
    checks++;
    if (req0_prdy !== 1'b1 || req1_prdy !== 1'b0) begin
      errors++; $display("FAIL midrst_first_gnt: got prdy0=%b prdy1=%b want 1 0", req0_prdy, req1_prdy);
    end
    drive_idle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      if (!(m_lock && m_lock_id == 0)) begin req0_pvld = ($urandom_range(0, 2) != 0); req0_pd = rnd_pd(); end
      if (!(m_lock && m_lock_id == 1)) begin req1_pvld = ($urandom_range(0, 2) != 0); req1_pd = rnd_pd(); end
      inp_in_prdy  = ($urandom_range(0, 3) != 0);
      inp_out_pvld = (tagq.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 40) == 0);
      inp_out_pd   = OW'($urandom);
      out0_prdy    = ($urandom_range(0, 3) != 0);
      out1_prdy    = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      model_eval();
      checks++;
      if ({inp_in_pvld, req0_prdy, req1_prdy} !== {e_in_pvld, e_prdy0, e_prdy1}) begin
        errors++; $display("FAIL rnd_issue n%0d: got %b want %b", n, {inp_in_pvld, req0_prdy, req1_prdy},
          {e_in_pvld, e_prdy0, e_prdy1});
      end
      checks++;
      if (e_in_pvld && inp_in_pd !== e_in_pd) begin
        errors++; $display("FAIL rnd_in_pd n%0d: got %h want %h", n, inp_in_pd[31:0], e_in_pd[31:0]);
      end
      checks++;
      if ({out0_pvld, out1_pvld, inp_out_prdy} !== {e_o0, e_o1, e_out_prdy}) begin
        errors++; $display("FAIL rnd_steer n%0d: got %b want %b", n, {out0_pvld, out1_pvld, inp_out_prdy},
          {e_o0, e_o1, e_out_prdy});
      end
      checks++;
      if (out0_pd !== inp_out_pd || out1_pd !== inp_out_pd) begin
        errors++; $display("FAIL rnd_out_pd n%0d: got %h/%h want %h", n, out0_pd, out1_pd, inp_out_pd);
      end
      checks++;
      if (outstanding !== 3'(tagq.size()) || tag_err !== m_err) begin
        errors++; $display("FAIL rnd_state n%0d: got outstanding=%0d err=%b want %0d %b", n, outstanding, tag_err,
          tagq.size(), m_err);
      end
      tick();
    end
  endtask

  initial begin
    drive_idle();
    model_reset();
    test_reset();
    test_alternate();
    test_lock();
    test_full();
    test_order();
    test_tag_err();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
